// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   FETCH_XLEN / FETCH_RESET_VECTOR / FETCH_PC_STEP : block defaults
//   fetch_entry_t   : one queued instruction {pc, data}
//   redirect_target : JAL/JALR target computation on a 64-bit datapath;
//                     callers keep the low XLEN bits.
package fetch_pkg;

    localparam int                    FETCH_XLEN         = 32;
    localparam int                    FETCH_MAX_XLEN     = 64;
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_VECTOR = 32'h0;
    localparam int                    FETCH_PC_STEP      = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] data;
    } fetch_entry_t;

    // JAL has priority when both enables are set. The low XLEN bits of the
    // sum do not depend on how the operands were extended to 64 bits, so
    // callers may zero-extend narrower operands.
    function automatic logic [FETCH_MAX_XLEN-1:0] redirect_target(
        input logic                      jal_en,
        input logic [FETCH_MAX_XLEN-1:0] ex_pc,
        input logic [FETCH_MAX_XLEN-1:0] imm,
        input logic [FETCH_MAX_XLEN-1:0] rs1
    );
        logic [FETCH_MAX_XLEN-1:0] t;
        if (jal_en) t = ex_pc + imm;
        else        t = (rs1 + imm) & ~{{(FETCH_MAX_XLEN-1){1'b0}}, 1'b1};
        return t;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched instructions for decode.
//   clock, reset : clock, synchronous active-high reset
//   push, push_entry : write one entry (accepted when not full or popping)
//   pop          : remove the head (ignored when empty)
//   flush        : empty the queue; overrides push and pop
//   head         : current head entry (registered storage, no bypass)
//   full, empty, count : occupancy status
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    parameter int  CW      = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          entries_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = entries_q[rd_ptr_q];

    always_comb begin
        // A pop frees the slot the push needs, so push-while-full is fine
        // when decode consumes in the same cycle.
        do_push  = push && !flush && (!full || pop);
        do_pop   = pop && !flush && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset: count/pointers gate visibility.
    always_ff @(posedge clock) begin
        if (do_push) entries_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: issues sequential PC requests to instruction
// memory, queues returned words with their PCs for decode, and applies
// JAL/JALR redirects by flushing the queue and discarding in-flight
// responses.
//   clock, reset                   : clock, synchronous active-high reset
//   imem_req_valid/ready/addr      : request channel to instruction memory
//   imem_rsp_valid/data            : in-order response channel, always accepted
//   inst_valid/ready/data/pc       : queue head towards decode
//   jal_en, jalr_en, ex_pc, imm, rs1 : redirect request from execute
//   redirect_busy                  : responses to discard still pending
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(FETCH_RESET_VECTOR),
    parameter int              QUEUE_DEPTH  = 4,
    parameter int              PC_STEP      = FETCH_PC_STEP
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            jal_en,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic            redirect_busy
);

    localparam int              CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam int              SW      = CW + 1;
    localparam logic [SW-1:0]   DEPTH_S = SW'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q,  fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q,    rsp_pc_d;
    logic [CW-1:0]   live_cnt_q,  live_cnt_d;
    logic [CW-1:0]   stale_cnt_q, stale_cnt_d;

    logic                      redirect;
    logic [FETCH_MAX_XLEN-1:0] target_wide;
    logic [XLEN-1:0]           target;
    logic                      req_fire, rsp_live, rsp_stale;
    logic [SW-1:0]             queue_credit_used, req_credit_used;

    entry_t          q_in, q_head;
    logic            q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]   q_count;
    // Upper target bits are meaningless when XLEN < 64, and the credit
    // scheme makes q_full redundant; both are deliberately left unread.
    logic            unused_ok;

    assign redirect    = jal_en | jalr_en;
    assign target_wide = redirect_target(jal_en, FETCH_MAX_XLEN'(ex_pc),
                                         FETCH_MAX_XLEN'(imm), FETCH_MAX_XLEN'(rs1));
    assign target      = target_wide[XLEN-1:0];
    assign unused_ok   = ^{target_wide, q_full};

    // Two credit pools: queue slots must cover every live response, and the
    // memory never sees more than QUEUE_DEPTH requests outstanding
    // (including ones whose answers will be discarded).
    assign queue_credit_used = SW'(q_count) + SW'(live_cnt_q);
    assign req_credit_used   = SW'(live_cnt_q) + SW'(stale_cnt_q);

    assign imem_req_valid = !reset && !redirect
                          && (queue_credit_used < DEPTH_S)
                          && (req_credit_used < DEPTH_S);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Stale responses are always older than live ones, so any response
    // seen while stale_cnt is non-zero belongs to a discarded request.
    assign rsp_stale = imem_rsp_valid && (stale_cnt_q != '0);
    assign rsp_live  = imem_rsp_valid && (stale_cnt_q == '0) && !redirect;

    assign q_push = rsp_live;
    assign q_in   = '{pc: rsp_pc_q, data: imem_rsp_data};

    assign inst_valid    = !reset && !redirect && !q_empty;
    assign inst_data     = q_head.data;
    assign inst_pc       = q_head.pc;
    assign q_pop         = inst_valid && inst_ready;
    assign redirect_busy = (stale_cnt_q != '0);

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        live_cnt_d  = live_cnt_q;
        stale_cnt_d = stale_cnt_q;
        if (redirect) begin
            fetch_pc_d  = target;
            rsp_pc_d    = target;
            // Every live request becomes stale; a response arriving now
            // retires one outstanding request whichever pool it came from.
            stale_cnt_d = stale_cnt_q + live_cnt_q - CW'(imem_rsp_valid);
            live_cnt_d  = '0;
        end else begin
            if (req_fire)  fetch_pc_d  = fetch_pc_q + STEP;
            if (rsp_live)  rsp_pc_d    = rsp_pc_q + STEP;
            if (rsp_stale) stale_cnt_d = stale_cnt_q - CW'(1);
            live_cnt_d = live_cnt_q + CW'(req_fire) - CW'(rsp_live);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q  <= RESET_VECTOR;
            rsp_pc_q    <= RESET_VECTOR;
            live_cnt_q  <= '0;
            stale_cnt_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            live_cnt_q  <= live_cnt_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t),
        .CW      (CW)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (q_push),
        .push_entry (q_in),
        .pop        (q_pop),
        .flush      (redirect),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

    localparam logic [31:0] RV = 32'h100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        inst_valid, inst_ready = 1'b1;
    logic [31:0] inst_data, inst_pc;
    logic        jal_en = 1'b0, jalr_en = 1'b0;
    logic [31:0] ex_pc = '0, imm = '0, rs1 = '0;
    logic        redirect_busy;

    always #5 clock = ~clock;

    fetch_queue_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .QUEUE_DEPTH(4), .PC_STEP(4)
    ) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .jal_en(jal_en), .jalr_en(jalr_en), .ex_pc(ex_pc), .imm(imm), .rs1(rs1),
        .redirect_busy(redirect_busy)
    );

    int          checks = 0, errors = 0;
    int          cyc = 0, lat = 1, fire_cnt = 0, pop_cnt = 0;
    logic [31:0] exp_pc = RV;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic sample();
        @(negedge clock); #1;
    endtask

    // Instruction memory model: in-order, fixed latency 'lat' cycles from
    // the request cycle; forgets everything on reset.
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];

    initial forever begin
        @(negedge clock);
        if (reset) begin
            pend.delete();
        end else begin
            if (imem_rsp_valid) void'(pend.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{imem_req_addr, cyc + lat});
                fire_cnt++;
            end
        end
        @(posedge clock); #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_f(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Decode-side scoreboard: every pop must be the next expected PC.
    initial forever begin
        @(negedge clock);
        if (!reset && inst_valid && inst_ready) begin
            check("pop_pc", inst_pc, exp_pc);
            check("pop_data", inst_data, mem_f(exp_pc));
            exp_pc += 32'd4;
            pop_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset(input int l, input logic rdy, input logic irdy);
        reset = 1'b1; jal_en = 1'b0; jalr_en = 1'b0;
        lat = l; imem_req_ready = rdy; inst_ready = irdy;
        step(); sample();
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_inst_valid", inst_valid, 1'b0);
        step();
        reset = 1'b0; fire_cnt = 0; pop_cnt = 0; exp_pc = RV;
    endtask

    typedef struct {
        string       name;
        logic        jal, jalr;
        logic [31:0] ex_pc, imm, rs1;
        logic [31:0] exp0, exp1, exp2;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{"jal_and_jalr", 1'b1, 1'b1, 32'h10, 32'h8, 32'h1001, 32'h18, 32'h1C, 32'h20};
        vecs[1] = '{"jalr_only", 1'b0, 1'b1, 32'h10, 32'h8, 32'h1001, 32'h1008, 32'h100C, 32'h1010};
        vecs[2] = '{"jal_fwd", 1'b1, 1'b0, 32'h200, 32'h40, 32'h0, 32'h240, 32'h244, 32'h248};
        vecs[3] = '{"jal_back", 1'b1, 1'b0, 32'h300, 32'hFFFF_FFF0, 32'h0, 32'h2F0, 32'h2F4, 32'h2F8};
        vecs[4] = '{"jalr_bit0", 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h2000, 32'h1FFE, 32'h2002, 32'h2006};
        vecs[5] = '{"jal_wrap", 1'b1, 1'b0, 32'hFFFF_FF00, 32'hF8, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};

        // Basic sequential fetch, 1-cycle memory.
        do_reset(1, 1'b1, 1'b1);
        sample();
        check1("c1_req_valid", imem_req_valid, 1'b1);
        check("c1_req_addr", imem_req_addr, 32'h100);
        check1("c1_inst_valid", inst_valid, 1'b0);
        check1("c1_busy", redirect_busy, 1'b0);
        step(); sample();
        check("c2_req_addr", imem_req_addr, 32'h104);
        check1("c2_no_bypass", inst_valid, 1'b0);
        step(); sample();
        check("c3_req_addr", imem_req_addr, 32'h108);
        check1("c3_inst_valid", inst_valid, 1'b1);
        repeat (5) step();
        sample();
        check1("basic_pops", pop_cnt >= 4, 1'b1);

        // Redirect vectors applied to a running steady-state stream.
        foreach (vecs[i]) begin
            repeat (6) step();
            jal_en = vecs[i].jal; jalr_en = vecs[i].jalr;
            ex_pc = vecs[i].ex_pc; imm = vecs[i].imm; rs1 = vecs[i].rs1;
            sample();
            check1({vecs[i].name, "_quiet_req"}, imem_req_valid, 1'b0);
            check1({vecs[i].name, "_quiet_inst"}, inst_valid, 1'b0);
            step();
            jal_en = 1'b0; jalr_en = 1'b0;
            exp_pc = vecs[i].exp0;
            sample();
            check1({vecs[i].name, "_valid0"}, imem_req_valid, 1'b1);
            check({vecs[i].name, "_addr0"}, imem_req_addr, vecs[i].exp0);
            step(); sample();
            check({vecs[i].name, "_addr1"}, imem_req_addr, vecs[i].exp1);
            step(); sample();
            check({vecs[i].name, "_addr2"}, imem_req_addr, vecs[i].exp2);
        end
        repeat (4) step();

        // Decode stall: queue fills to 4 and requests stop, then drain.
        do_reset(1, 1'b1, 1'b0);
        repeat (9) step();
        sample();
        check1("stall_req_off", imem_req_valid, 1'b0);
        check("stall_fires", 32'(fire_cnt), 32'd4);
        check1("stall_head_valid", inst_valid, 1'b1);
        check("stall_head_pc", inst_pc, 32'h100);
        step();
        inst_ready = 1'b1;
        repeat (8) step();
        sample();
        check1("stall_drain", pop_cnt >= 4, 1'b1);

        // Redirect with three requests outstanding, 3-cycle memory.
        do_reset(3, 1'b1, 1'b1);
        step(); step(); step();
        jal_en = 1'b1; ex_pc = 32'h200; imm = 32'h40;
        sample();
        check("outst_fires", 32'(fire_cnt), 32'd3);
        step();
        jal_en = 1'b0;
        exp_pc = 32'h240;
        sample();
        check1("outst_busy", redirect_busy, 1'b1);
        check("outst_addr", imem_req_addr, 32'h240);
        n = 0;
        while (redirect_busy && n < 8) begin step(); sample(); n++; end
        check1("outst_busy_clear", redirect_busy, 1'b0);
        n = 0;
        while (!inst_valid && n < 12) begin step(); sample(); n++; end
        check1("outst_first_valid", inst_valid, 1'b1);
        check("outst_first_pc", inst_pc, 32'h240);
        repeat (4) step();

        // Reset with the queue at full credit and two responses in flight.
        do_reset(3, 1'b1, 1'b0);
        repeat (5) step();
        sample();
        check1("mid_req_off", imem_req_valid, 1'b0);
        check1("mid_inst_valid", inst_valid, 1'b1);
        check("mid_inst_pc", inst_pc, 32'h100);
        step();
        reset = 1'b1; exp_pc = RV;
        sample();
        check1("mid_rst_req", imem_req_valid, 1'b0);
        check1("mid_rst_inst", inst_valid, 1'b0);
        step();
        reset = 1'b0; pop_cnt = 0;
        sample();
        check1("post_rst_req_valid", imem_req_valid, 1'b1);
        check("post_rst_addr", imem_req_addr, RV);
        check1("post_rst_inst_valid", inst_valid, 1'b0);
        check1("post_rst_busy", redirect_busy, 1'b0);
        step();
        inst_ready = 1'b1;
        repeat (12) step();
        sample();
        check1("post_rst_pops", pop_cnt >= 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end with request/response instruction-memory handshake and a decoupling instruction queue. It issues sequential PC requests, buffers returned instructions with their PCs for decode, and applies JAL/JALR redirects. On a redirect it flushes the queue and silently discards responses still in flight. It sits between the instruction memory port and the decode stage, and replaces the single-register PC generator.

## Interface
- XLEN, 32: PC, immediate and instruction width.
- RESET_VECTOR, 32'h0: fetch PC loaded by reset.
- QUEUE_DEPTH, 4: queue entries; power of two, ≥2. Also the cap on outstanding requests.
- PC_STEP, 4: sequential PC increment.

- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response valid; in order, always accepted.
- imem_rsp_data  in  XLEN  instruction word.
- inst_valid  out  1  queue head valid to decode.
- inst_ready  in  1  decode consumes head; low = stall.
- inst_data  out  XLEN  head instruction.
- inst_pc  out  XLEN  head PC.
- jal_en  in  1  JAL redirect.
- jalr_en  in  1  JALR redirect.
- ex_pc  in  XLEN  PC of the redirecting instruction.
- imm  in  XLEN  sign-extended immediate.
- rs1  in  XLEN  JALR base.
- redirect_busy  out  1  stale responses still pending.

## Operation
- Registers:
  - fetch_pc: next request address.
  - rsp_pc: PC of the next live response.
  - live_cnt, stale_cnt: 0..QUEUE_DEPTH each.
  - Queue of {pc, data}.
- Request:
  - imem_req_valid = !redirect && (occupancy + live_cnt < QUEUE_DEPTH) && (live_cnt + stale_cnt < QUEUE_DEPTH).
  - imem_req_addr = fetch_pc.
  - On fire (valid && ready): fetch_pc += PC_STEP (modulo 2^XLEN) and live_cnt++.
- Response handling:
  - If stale_cnt > 0, the response is dropped and stale_cnt decrements.
  - Otherwise it is enqueued as {rsp_pc, data}, rsp_pc += PC_STEP and live_cnt decrements.
  - Stale responses are always older than live ones, so stale responses are consumed first.
- Dequeue: inst_valid && inst_ready pops the head.
- Redirect (redirect = jal_en || jalr_en):
  - If both are asserted, JAL wins.
  - JAL target = ex_pc + imm.
  - JALR target = (rs1 + imm) & ~1.
  - On a redirect cycle:
    - fetch_pc and rsp_pc load the target.
    - The queue is cleared.
    - stale_cnt += live_cnt, minus 1 if a response arrives in this cycle.
    - live_cnt = 0.
    - Any response arriving in this cycle is dropped.
    - imem_req_valid and inst_valid are forced 0, so no pop occurs.
- Stall: inst_ready low holds the head. Credits prevent overflow, so no response is ever lost.
- redirect_busy = (stale_cnt != 0).

## Timing
- Reset values:
  - fetch_pc = rsp_pc = RESET_VECTOR.
  - Counters 0, queue empty.
  - imem_req_valid = 0 and inst_valid = 0 while reset is high.
- First request: cycle 1 after reset deasserts, address RESET_VECTOR.
- Latency: a response enqueued at edge N is visible on inst_valid in cycle N+1. Queue data path is registered; no response-to-inst bypass.
- Redirect in cycle N: first request to the target is issued in N+1.
- Simultaneous events:
  - Enqueue + pop when full: legal; occupancy unchanged.
  - Request fire + live response in the same cycle: live_cnt unchanged.
  - Reset overrides everything, including a mid-flight redirect and pending stale responses. After reset the memory must not deliver responses to pre-reset requests.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 → 32'h0, with no error.

## Structure
- Shared package fetch_pkg:
  - XLEN default.
  - Reset-vector default.
  - PC_STEP.
  - Typedef fetch_entry_t {pc, data}.
  - Function computing the redirect target (JAL/JALR priority and bit-0 clear).
- One sub-module, fetch_queue:
  - Synchronous FIFO of fetch_entry_t, depth QUEUE_DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Counter and credit logic stay in fetch_queue_unit.

## Test plan
- Reset with RESET_VECTOR = 32'h100, imem_req_ready = 1, 1-cycle response latency:
  - Requests go out at 0x100, 0x104, 0x108.
  - inst_pc/inst_data come out in order with matching data.
- inst_ready = 0 for 10 cycles, QUEUE_DEPTH = 4:
  - Exactly 4 entries are queued, then imem_req_valid deasserts.
  - Releasing the stall drains 0x100..0x10C with no loss.
- Three requests outstanding (3-cycle latency), then jal_en with ex_pc = 0x200, imm = 0x40:
  - redirect_busy goes high.
  - The three stale responses are dropped.
  - The first inst_pc after the redirect is 0x240.
- jal_en and jalr_en together, ex_pc = 0x10, imm = 8, rs1 = 0x1001:
  - JAL wins; target 0x18.
  - jalr_en alone with the same inputs gives 0x1008.
- fetch_pc at 32'hFFFF_FFF8:
  - Requests go to 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Assert reset while 2 responses are outstanding and the queue is full:
  - All outputs return to reset values next cycle.
  - After reset deasserts, fetch restarts at RESET_VECTOR.
